regfile_scoreboard: RTL and testbench

//   Write-port receiver for the WB stage's rf_we/rf_waddr/rf_wdata: holds the general register file,

---
 rtl/regfile_scoreboard_if.sv | 33 +++
 rtl/regfile_scoreboard.sv | 118 +++++++++++
 tb/tb_regfile_scoreboard.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/regfile_scoreboard_if.sv
// Bundle between the pipeline (ID issue / WB write-back) and the register file scoreboard.
// The pipeline side drives requests; the register file side returns read data and hazard status.
interface regfile_scoreboard_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [AW-1:0] raddr1;
  logic [AW-1:0] raddr2;
  logic [DW-1:0] rdata1;
  logic [DW-1:0] rdata2;
  logic          rs1_used;
  logic          rs2_used;
  logic          issue_valid;
  logic          issue_gr_we;
  logic [AW-1:0] issue_dest;
  logic          hazard_stall;
  logic          err_sticky;

  modport master (
    output we, waddr, wdata, raddr1, raddr2, rs1_used, rs2_used,
           issue_valid, issue_gr_we, issue_dest,
    input  rdata1, rdata2, hazard_stall, err_sticky
  );

  modport slave (
    input  we, waddr, wdata, raddr1, raddr2, rs1_used, rs2_used,
           issue_valid, issue_gr_we, issue_dest,
    output rdata1, rdata2, hazard_stall, err_sticky
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// General register file with write-through read ports and per-register pending-write counters
// that raise hazard_stall while a source register still has an older write in flight.
module regfile_scoreboard #(
  parameter int NREG  = 32,
  parameter int AW    = 5,
  parameter int DW    = 32,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  regfile_scoreboard_if.slave rf
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [AW-1:0]    ADDR_ZERO = {AW{1'b0}};

  logic [DW-1:0]    rf_r       [NREG];
  logic [CNT_W-1:0] pend_r     [NREG];
  logic [CNT_W-1:0] pend_nxt_s [NREG];
  logic             err_r;
  logic             err_set_s;
  logic             inc_s;
  logic             dec_s;
  logic             inc_hit_s;
  logic             dec_hit_s;
  logic             h1_s;
  logic             h2_s;
  logic             stall_s;
  logic [DW-1:0]    rdata1_s;
  logic [DW-1:0]    rdata2_s;

  // Read ports: r0 is hardwired zero, a same-cycle write-back is forwarded
  always_comb begin
    rdata1_s = {DW{1'b0}};
    rdata2_s = {DW{1'b0}};
    if (rf.raddr1 == ADDR_ZERO) begin
      rdata1_s = {DW{1'b0}};
    end else if (rf.we && (rf.waddr == rf.raddr1)) begin
      rdata1_s = rf.wdata;
    end else begin
      rdata1_s = rf_r[rf.raddr1];
    end
    if (rf.raddr2 == ADDR_ZERO) begin
      rdata2_s = {DW{1'b0}};
    end else if (rf.we && (rf.waddr == rf.raddr2)) begin
      rdata2_s = rf.wdata;
    end else begin
      rdata2_s = rf_r[rf.raddr2];
    end
  end

  // Hazard detection: a lone pending write landing this cycle is covered by the bypass
  always_comb begin
    h1_s = rf.rs1_used && (rf.raddr1 != ADDR_ZERO) && (pend_r[rf.raddr1] != CNT_ZERO)
           && !((pend_r[rf.raddr1] == CNT_ONE) && rf.we && (rf.waddr == rf.raddr1));
    h2_s = rf.rs2_used && (rf.raddr2 != ADDR_ZERO) && (pend_r[rf.raddr2] != CNT_ZERO)
           && !((pend_r[rf.raddr2] == CNT_ONE) && rf.we && (rf.waddr == rf.raddr2));
    stall_s = h1_s | h2_s;
    inc_s = rf.issue_valid && rf.issue_gr_we && (rf.issue_dest != ADDR_ZERO) && !stall_s;
    dec_s = rf.we && (rf.waddr != ADDR_ZERO);
  end

  // Next pending counts; overflow saturates, underflow holds at zero, both flag an error
  always_comb begin
    pend_nxt_s = pend_r;
    err_set_s  = 1'b0;
    inc_hit_s  = 1'b0;
    dec_hit_s  = 1'b0;
    for (int r = 1; r < NREG; r++) begin
      inc_hit_s = inc_s && (rf.issue_dest == AW'(r));
      dec_hit_s = dec_s && (rf.waddr == AW'(r));
      case ({inc_hit_s, dec_hit_s})
        2'b10: begin
          if (pend_r[r] == CNT_MAX) begin
            err_set_s = 1'b1;
          end else begin
            pend_nxt_s[r] = pend_r[r] + CNT_ONE;
          end
        end
        2'b01: begin
          if (pend_r[r] == CNT_ZERO) begin
            err_set_s = 1'b1;
          end else begin
            pend_nxt_s[r] = pend_r[r] - CNT_ONE;
          end
        end
        default: pend_nxt_s[r] = pend_r[r];
      endcase
    end
  end

  // State: register array, pending counters and sticky error flag
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) begin
        rf_r[r]   <= {DW{1'b0}};
        pend_r[r] <= CNT_ZERO;
      end
      err_r <= 1'b0;
    end else begin
      if (dec_s) begin
        rf_r[rf.waddr] <= rf.wdata;
      end
      pend_r <= pend_nxt_s;
      if (err_set_s) begin
        err_r <= 1'b1;
      end
    end
  end

  assign rf.rdata1       = rdata1_s;
  assign rf.rdata2       = rdata2_s;
  assign rf.hazard_stall = stall_s;
  assign rf.err_sticky   = err_r;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: bypass, r0 handling, hazard timing,
// counter saturation/underflow and reset behaviour.
module tb_regfile_scoreboard;

  logic clk;
  logic reset;
  int   checks_cnt;
  int   errors_cnt;

  regfile_scoreboard_if #(.AW(5), .DW(32)) bus ();

  regfile_scoreboard #(.NREG(32), .AW(5), .DW(32), .CNT_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .rf    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.we = 1'b0; bus.waddr = 5'd0; bus.wdata = 32'd0;
    bus.raddr1 = 5'd0; bus.raddr2 = 5'd0;
    bus.rs1_used = 1'b0; bus.rs2_used = 1'b0;
    bus.issue_valid = 1'b0; bus.issue_gr_we = 1'b0; bus.issue_dest = 5'd0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] dest);
    bus.issue_valid = 1'b1; bus.issue_gr_we = 1'b1; bus.issue_dest = dest;
    step();
    bus.issue_valid = 1'b0; bus.issue_gr_we = 1'b0; bus.issue_dest = 5'd0;
  endtask

  task automatic retire(input logic [4:0] addr, input logic [31:0] data);
    bus.we = 1'b1; bus.waddr = addr; bus.wdata = data;
    step();
    bus.we = 1'b0; bus.waddr = 5'd0; bus.wdata = 32'd0;
  endtask

  initial begin
    checks_cnt = 0;
    errors_cnt = 0;
    idle();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;

    // reset state
    bus.raddr1 = 5'd5; bus.raddr2 = 5'd0; bus.rs1_used = 1'b1; bus.rs2_used = 1'b1;
    #1;
    check_eq("rst_rdata1", bus.rdata1, 32'd0);
    check_eq("rst_rdata2", bus.rdata2, 32'd0);
    check_eq("rst_stall", {31'd0, bus.hazard_stall}, 32'd0);
    check_eq("rst_err", {31'd0, bus.err_sticky}, 32'd0);

    // write-through bypass; write with no pending entry underflows but still lands
    bus.we = 1'b1; bus.waddr = 5'd3; bus.wdata = 32'hDEAD_BEEF;
    bus.raddr1 = 5'd3; bus.raddr2 = 5'd3;
    #1;
    check_eq("bypass_rdata1", bus.rdata1, 32'hDEAD_BEEF);
    check_eq("bypass_rdata2", bus.rdata2, 32'hDEAD_BEEF);
    step();
    bus.we = 1'b0; bus.waddr = 5'd0; bus.wdata = 32'd0;
    #1;
    check_eq("array_rdata1", bus.rdata1, 32'hDEAD_BEEF);
    check_eq("underflow_err", {31'd0, bus.err_sticky}, 32'd1);
    check_eq("underflow_stall", {31'd0, bus.hazard_stall}, 32'd0);

    // reset mid-operation overrides a concurrent write and issue
    reset = 1'b1;
    bus.we = 1'b1; bus.waddr = 5'd3; bus.wdata = 32'h0000_0055;
    bus.issue_valid = 1'b1; bus.issue_gr_we = 1'b1; bus.issue_dest = 5'd3;
    step();
    reset = 1'b0;
    idle();
    bus.raddr1 = 5'd3; bus.rs1_used = 1'b1;
    #1;
    check_eq("midrst_rdata1", bus.rdata1, 32'd0);
    check_eq("midrst_stall", {31'd0, bus.hazard_stall}, 32'd0);
    check_eq("midrst_err", {31'd0, bus.err_sticky}, 32'd0);

    // producer to r7, dependent stalls until WB; an issue attempted while stalled is dropped
    idle();
    issue(5'd7);
    bus.raddr1 = 5'd7; bus.rs1_used = 1'b1;
    bus.issue_valid = 1'b1; bus.issue_gr_we = 1'b1; bus.issue_dest = 5'd12;
    #1;
    check_eq("dep_stall_c1", {31'd0, bus.hazard_stall}, 32'd1);
    step();
    bus.issue_valid = 1'b0; bus.issue_gr_we = 1'b0; bus.issue_dest = 5'd0;
    #1;
    check_eq("dep_stall_c2", {31'd0, bus.hazard_stall}, 32'd1);
    step();
    bus.we = 1'b1; bus.waddr = 5'd7; bus.wdata = 32'h0000_0077;
    #1;
    check_eq("dep_stall_wb", {31'd0, bus.hazard_stall}, 32'd0);
    check_eq("dep_rdata_wb", bus.rdata1, 32'h0000_0077);
    step();
    bus.we = 1'b0; bus.waddr = 5'd0; bus.wdata = 32'd0;
    bus.raddr2 = 5'd12; bus.rs2_used = 1'b1;
    #1;
    check_eq("dep_stall_after", {31'd0, bus.hazard_stall}, 32'd0);
    check_eq("dep_rdata_after", bus.rdata1, 32'h0000_0077);
    check_eq("gated_issue_err", {31'd0, bus.err_sticky}, 32'd0);

    // three writes in flight to r4, drained one at a time
    idle();
    issue(5'd4); issue(5'd4); issue(5'd4);
    bus.raddr1 = 5'd4; bus.rs1_used = 1'b1;
    bus.we = 1'b1; bus.waddr = 5'd4; bus.wdata = 32'h0000_0041;
    #1;
    check_eq("r4_pend3_wb", {31'd0, bus.hazard_stall}, 32'd1);
    step();
    bus.we = 1'b0;
    #1;
    check_eq("r4_pend2", {31'd0, bus.hazard_stall}, 32'd1);
    bus.we = 1'b1; bus.wdata = 32'h0000_0042;
    #1;
    check_eq("r4_pend2_wb", {31'd0, bus.hazard_stall}, 32'd1);
    step();
    bus.wdata = 32'h0000_0043;
    #1;
    check_eq("r4_pend1_wb", {31'd0, bus.hazard_stall}, 32'd0);
    step();
    bus.we = 1'b0; bus.waddr = 5'd0; bus.wdata = 32'd0;
    #1;
    check_eq("r4_drained", {31'd0, bus.hazard_stall}, 32'd0);
    check_eq("r4_rdata", bus.rdata1, 32'h0000_0043);
    check_eq("r4_err", {31'd0, bus.err_sticky}, 32'd0);

    // simultaneous issue and retire on r10 leave the count unchanged
    idle();
    issue(5'd10);
    bus.we = 1'b1; bus.waddr = 5'd10; bus.wdata = 32'h0000_00A0;
    bus.issue_valid = 1'b1; bus.issue_gr_we = 1'b1; bus.issue_dest = 5'd10;
    step();
    idle();
    bus.raddr1 = 5'd10; bus.rs1_used = 1'b1;
    #1;
    check_eq("r10_still_pend", {31'd0, bus.hazard_stall}, 32'd1);
    retire(5'd10, 32'h0000_00A1);
    #1;
    check_eq("r10_drained", {31'd0, bus.hazard_stall}, 32'd0);
    check_eq("r10_err", {31'd0, bus.err_sticky}, 32'd0);

    // r0: writes dropped, never pending
    idle();
    bus.we = 1'b1; bus.waddr = 5'd0; bus.wdata = 32'd1;
    bus.raddr1 = 5'd0; bus.rs1_used = 1'b1;
    #1;
    check_eq("r0_bypass", bus.rdata1, 32'd0);
    step();
    bus.we = 1'b0; bus.wdata = 32'd0;
    issue(5'd0);
    bus.raddr2 = 5'd0; bus.rs2_used = 1'b1;
    #1;
    check_eq("r0_rdata", bus.rdata1, 32'd0);
    check_eq("r0_stall", {31'd0, bus.hazard_stall}, 32'd0);
    check_eq("r0_err", {31'd0, bus.err_sticky}, 32'd0);

    // overflow: four issues to r9 saturate and set the sticky flag
    idle();
    issue(5'd9); issue(5'd9); issue(5'd9);
    #1;
    check_eq("r9_pend3_err", {31'd0, bus.err_sticky}, 32'd0);
    issue(5'd9);
    bus.raddr1 = 5'd9; bus.rs1_used = 1'b1;
    #1;
    check_eq("ovf_err", {31'd0, bus.err_sticky}, 32'd1);
    check_eq("ovf_stall", {31'd0, bus.hazard_stall}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check_eq("ovf_rst_err", {31'd0, bus.err_sticky}, 32'd0);
    check_eq("ovf_rst_stall", {31'd0, bus.hazard_stall}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
